input_debounce_sync: RTL

Conditions a raw asynchronous serial input (push-button or off-chip bit line) before it reaches the sequence-recognising Moore FSM.
- Synchronises the input through a flop chain.
- Filters glitches with a counter-based debounce state machine.
- Drives a clean, registered level (`level_out`) that connects directly to the FSM's `in` port.
- Produces single-cycle rise/fall strobes and a saturating glitch counter for debug.

---
 rtl/input_debounce_sync.sv | 107 ++++++++++
 1 files changed

// File: rtl/input_debounce_sync.sv
// Input conditioner: synchronises an asynchronous raw bit, debounces it with a
// counter-based FSM and presents a clean registered level plus edge strobes.
module input_debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_in,
    input  logic       en,
    output logic       level_out,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy,
    output logic [7:0] glitch_cnt,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;

    // raw_in is consumed only by the first synchroniser flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= STABLE_LO;
            cnt        <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            glitch_cnt <= 8'd0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (s) begin
                        state <= PEND_HI;
                        cnt   <= '0;
                    end
                end
                PEND_HI: begin
                    // An input reverting aborts the change even on en=0 cycles.
                    if (!s) begin
                        state <= STABLE_LO;
                        if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
                    end else if (en && cnt == CNT_LAST) begin
                        state      <= STABLE_HI;
                        level_out  <= 1'b1;
                        rise_pulse <= 1'b1;
                        cnt        <= '0;
                    end else if (en) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state <= PEND_LO;
                        cnt   <= '0;
                    end
                end
                PEND_LO: begin
                    if (s) begin
                        state <= STABLE_HI;
                        if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
                    end else if (en && cnt == CNT_LAST) begin
                        state      <= STABLE_LO;
                        level_out  <= 1'b0;
                        fall_pulse <= 1'b1;
                        cnt        <= '0;
                    end else if (en) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy      = (state == PEND_HI) || (state == PEND_LO);
    assign state_dbg = state;

endmodule
